// File: rtl/stack_ctrl_if.sv
// Command handshake between the stack datapath sequencer and stack_ctrl.
// The master presents a command; the slave (stack_ctrl) signals readiness.
interface stack_ctrl_if #(
  parameter int CW = 4
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [CW-1:0] load_count;
  logic          cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output load_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  load_count,
    output cmd_ready
  );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencing controller for a stack built from parallel-load shift registers.
// Flushes the non-resettable slice array after reset, then accepts
// push/pop/load commands one at a time, tracks depth and flags errors.
// The op encoding equals the slice sel encoding (01 load, 10 shl, 11 shr),
// so during EXEC the latched op drives sel directly.
module stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  stack_ctrl_if.slave   cmd,
  output logic          sel1,
  output logic          sel0,
  output logic          ILeft,
  output logic          IRight,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FL_INIT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_IDLE = 2'b01,
    S_EXEC = 2'b10
  } state_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  op_t           op_in;
  logic [CW-1:0] load_q, load_d;
  logic [CW-1:0] fl_q, fl_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          ready_c;
  logic [1:0]    sel_c;

  assign op_in = op_t'(cmd.cmd_op);

  // Next-state, counter updates, and output decode from registered state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    load_d  = load_q;
    fl_d    = fl_q;
    count_d = count_q;
    err_d   = 1'b0;
    ready_c = 1'b0;
    sel_c   = 2'b00;

    case (state_q)
      S_INIT: begin
        // Shift right with zero fill clears the uninitialised slice bits.
        sel_c = 2'b11;
        if (fl_q == '0) state_d = S_IDLE;
        else            fl_d    = fl_q - 1'b1;
      end

      S_IDLE: begin
        ready_c = 1'b1;
        if (cmd.cmd_valid) begin
          case (op_in)
            OP_PUSH: begin
              if (full) err_d = 1'b1;
              else begin
                op_d    = OP_PUSH;
                state_d = S_EXEC;
              end
            end
            OP_POP: begin
              if (empty) err_d = 1'b1;
              else begin
                op_d    = OP_POP;
                state_d = S_EXEC;
              end
            end
            OP_LOAD: begin
              if (cmd.load_count > DEPTH_C) err_d = 1'b1;
              else begin
                op_d    = OP_LOAD;
                load_d  = cmd.load_count;
                state_d = S_EXEC;
              end
            end
            default: ;  // nop: accepted, no effect
          endcase
        end
      end

      S_EXEC: begin
        sel_c   = op_q;
        state_d = S_IDLE;
        case (op_q)
          OP_PUSH: count_d = count_q + 1'b1;
          OP_POP:  count_d = count_q - 1'b1;
          OP_LOAD: count_d = load_q;
          default: ;
        endcase
      end

      default: state_d = S_INIT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_INIT;
      op_q    <= OP_NOP;
      load_q  <= '0;
      fl_q    <= FL_INIT;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      load_q  <= load_d;
      fl_q    <= fl_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign cmd.cmd_ready = ready_c;
  assign sel1          = sel_c[1];
  assign sel0          = sel_c[0];
  assign ILeft         = 1'b0;
  assign IRight        = 1'b0;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign err           = err_q;

endmodule
